frame_cache_stack: RTL and testbench
====================================

// Module: frame_cache_stack
// PURPOSE
//  Parametrised call-frame backup stack for the 16-bit datapath. On backup it pushes {RA, register-file
//  snapshot}; on restore it pops. The top frame is driven combinationally so the register management
//  system can reload in the same cycle as restore. Adds configurable depth, width and register count,
//  swap (tail call), full/empty, sticky error flags, a depth count and a high-water mark.
// PARAMETERS
//  WIDTH  16  data/register width in bits
//  NREGS  15  registers captured per frame (regs bus = NREGS*WIDTH; default 240)
//  DEPTH  8   frames held; >=2
// PORTS
//  clk        in   1                    rising-edge clock
//  reset      in   1                    asynchronous, active-high reset
//  backup     in   1                    push request, sampled at posedge clk
//  restore    in   1                    pop request, sampled at posedge clk
//  clr_err    in   1                    clears overflow, underflow and max_depth
//  ra_in      in   WIDTH                return address to save
//  regs_in    in   NREGS*WIDTH          register snapshot to save
//  ra_out     out  WIDTH                RA of top frame (combinational)
//  regs_out   out  NREGS*WIDTH          registers of top frame (combinational)
//  depth      out  $clog2(DEPTH+1)      frames currently held
//  max_depth  out  $clog2(DEPTH+1)      high-water mark of depth
//  full       out  1                    depth==DEPTH
//  empty      out  1                    depth==0
//  overflow   out  1                    sticky: push refused while full
//  underflow  out  1                    sticky: pop refused while empty
//  ack        out  1                    one-cycle pulse, cycle after any accepted op
// BEHAVIOUR
//  - Frame = {ra, regs}, FRAME_W=(NREGS+1)*WIDTH. Entry i is stored at slot i; the top is slot depth-1.
//  - Reset (async): depth=0, max_depth=0, overflow=0, underflow=0, ack=0, so empty=1 and full=0.
//    Storage is not reset. A reset mid-operation discards the pending op.
//  - ra_out/regs_out = slot[depth-1] when !empty, else all zeros. No clock latency.
//  - Per posedge, op = {backup, restore}:
//    00 NONE: hold.
//    10 PUSH: if !full, write slot[depth] and depth+1. If full, no write, depth held, overflow<=1.
//    01 POP:  if !empty, depth-1 (slot contents are untouched). If empty, depth held, underflow<=1.
//    11 SWAP: if !empty, overwrite slot[depth-1] and depth held. If empty, behave as PUSH (slot0,
//         depth=1, no flag). SWAP while full is legal and does not overflow.
//  - ack<=1 the cycle after an accepted PUSH, POP or SWAP. It is 0 after refused ops and after NONE.
//  - max_depth<=max(max_depth, next depth) every cycle.
//  - clr_err: overflow, underflow and max_depth are cleared at the edge, then max_depth reloads to
//    the current next depth. If an error occurs in the same cycle, the set wins over the clear.
//  - full/empty are decoded combinationally from the registered depth.
//  - Depth arithmetic is unsigned, width $clog2(DEPTH+1), and never wraps (saturating by the rules above).
// STRUCTURE
//  - Package fcs_pkg: function frame_w(WIDTH,NREGS); localparams OP_NONE=2'b00, OP_POP=2'b01,
//    OP_PUSH=2'b10, OP_SWAP=2'b11.
//  - Sub-module fcs_frame_ram: DEPTH x FRAME_W flop array, one synchronous write port
//    (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
//  - Top level: op decode, depth/max_depth counters, sticky flags, ack register, zero-mask on the read path.
// TESTING
//  1 Reset, then 3 PUSH with RA=0x0010/0x0020/0x0030 and regs=i*0x0101 -> depth 3, ra_out=0x0030,
//    ack pulses 3x. Then 3 POP -> ra_out 0x0020, 0x0010, then 0 with empty=1.
//  2 DEPTH=8: 9 PUSH -> depth=8, full=1, overflow=1 on the 9th; slot7 keeps the 8th data; no ack on the 9th.
//  3 POP while empty -> underflow=1, depth=0, outputs 0. Then clr_err -> underflow=0.
//    clr_err + POP in the same empty cycle -> underflow stays 1.
//  4 SWAP at depth 2 with RA=0xBEEF -> depth=2, ra_out=0xBEEF, slot0 intact.
//    SWAP at depth 0 -> depth=1. SWAP at full -> no overflow.
//  5 Push 5, pop 5 -> max_depth=5. clr_err -> max_depth=0.
//  6 Assert reset async mid-PUSH at depth 4 -> depth=0, flags 0, ack 0 immediately with no clock edge.
//    Re-run 1 with NREGS=7, WIDTH=32, DEPTH=4.

Source files
------------

// File: rtl/fcs_pkg.sv
// Shared definitions for the call-frame backup stack: frame width helper and op encodings.
package fcs_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    function automatic int frame_w(input int width, input int nregs);
        return (nregs + 1) * width;
    endfunction

endpackage

// File: rtl/fcs_frame_ram.sv
// Frame storage: DEPTH x FRAME_W flop array, one synchronous write port, one asynchronous read port.
module fcs_frame_ram #(
    parameter int DEPTH = 8,
    parameter int FW    = 256,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [FW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [FW-1:0] rdata
);

    logic [FW-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the top masks reads while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_cache_stack.sv
// Call-frame backup stack: push/pop/swap of {RA, register snapshot} with depth tracking,
// sticky error flags, a high-water mark and a combinational top-of-stack read path.
module frame_cache_stack
    import fcs_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 15,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       backup,
    input  logic                       restore,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           ra_in,
    input  logic [NREGS*WIDTH-1:0]     regs_in,
    output logic [WIDTH-1:0]           ra_out,
    output logic [NREGS*WIDTH-1:0]     regs_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [$clog2(DEPTH+1)-1:0] max_depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       ack
);

    localparam int FW = frame_w(WIDTH, NREGS);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] ONE   = DW'(1);
    localparam logic [DW-1:0] D_MAX = DW'(DEPTH);

    logic [DW-1:0] depth_q, depth_d;
    logic [DW-1:0] max_q, max_d, max_base;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          ack_q, ack_d;
    logic          is_full, is_empty;
    op_e           op;
    logic          we;
    logic [AW-1:0] waddr, raddr;
    logic [FW-1:0] rdata;

    assign is_full  = (depth_q == D_MAX);
    assign is_empty = (depth_q == '0);

    always_comb begin
        op       = op_e'({backup, restore});
        depth_d  = depth_q;
        we       = 1'b0;
        waddr    = AW'(depth_q);
        ack_d    = 1'b0;
        ovf_d    = clr_err ? 1'b0 : ovf_q;
        udf_d    = clr_err ? 1'b0 : udf_q;
        case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    depth_d = depth_q + ONE;
                    ack_d   = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    depth_d = depth_q - ONE;
                    ack_d   = 1'b1;
                end else begin
                    udf_d = 1'b1;
                end
            end
            OP_SWAP: begin
                // Swap on an empty stack degenerates to a push into slot 0.
                we    = 1'b1;
                ack_d = 1'b1;
                if (!is_empty) begin
                    waddr = AW'(depth_q - ONE);
                end else begin
                    depth_d = ONE;
                end
            end
            default: ;
        endcase
        max_base = clr_err ? '0 : max_q;
        max_d    = (depth_d > max_base) ? depth_d : max_base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            ack_q   <= ack_d;
        end
    end

    assign raddr = AW'(depth_q - ONE);

    fcs_frame_ram #(
        .DEPTH (DEPTH),
        .FW    (FW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata ({ra_in, regs_in}),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign ra_out    = is_empty ? '0 : rdata[FW-1 -: WIDTH];
    assign regs_out  = is_empty ? '0 : rdata[NREGS*WIDTH-1:0];
    assign depth     = depth_q;
    assign max_depth = max_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign ack       = ack_q;

endmodule

// File: tb/tb_frame_cache_stack.sv
// Bench for frame_cache_stack: directed scenarios plus random ops against a queue-based model,
// and a second instance with WIDTH=32, NREGS=7, DEPTH=4.
module tb_frame_cache_stack;

    typedef struct {
        logic [15:0]  ra;
        logic [239:0] regs;
    } frame_t;

    logic         clk = 1'b0;
    logic         reset, backup, restore, clr_err;
    logic [15:0]  ra_in;
    logic [239:0] regs_in;
    logic [15:0]  ra_out;
    logic [239:0] regs_out;
    logic [3:0]   depth, max_depth;
    logic         full, empty, overflow, underflow, ack;

    logic         s_reset, s_backup, s_restore, s_clr_err;
    logic [31:0]  s_ra_in;
    logic [223:0] s_regs_in;
    logic [31:0]  s_ra_out;
    logic [223:0] s_regs_out;
    logic [2:0]   s_depth, s_max_depth;
    logic         s_full, s_empty, s_overflow, s_underflow, s_ack;

    int n_vec = 0;
    int n_err = 0;

    frame_t mq[$];
    logic   m_ovf, m_udf, m_ack;
    int     m_max;

    always #5 clk = ~clk;

    frame_cache_stack u_dut (
        .clk(clk), .reset(reset), .backup(backup), .restore(restore), .clr_err(clr_err),
        .ra_in(ra_in), .regs_in(regs_in), .ra_out(ra_out), .regs_out(regs_out),
        .depth(depth), .max_depth(max_depth), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .ack(ack)
    );

    frame_cache_stack #(.WIDTH(32), .NREGS(7), .DEPTH(4)) u_small (
        .clk(clk), .reset(s_reset), .backup(s_backup), .restore(s_restore), .clr_err(s_clr_err),
        .ra_in(s_ra_in), .regs_in(s_regs_in), .ra_out(s_ra_out), .regs_out(s_regs_out),
        .depth(s_depth), .max_depth(s_max_depth), .full(s_full), .empty(s_empty),
        .overflow(s_overflow), .underflow(s_underflow), .ack(s_ack)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ack = 1'b0;
        m_max = 0;
    endtask

    task automatic model_step(input logic b, input logic r, input logic c, input frame_t f);
        logic so = 1'b0;
        logic su = 1'b0;
        m_ack = 1'b0;
        if (b && r) begin
            if (mq.size() == 0) mq.push_back(f);
            else mq[mq.size()-1] = f;
            m_ack = 1'b1;
        end else if (b) begin
            if (mq.size() < 8) begin mq.push_back(f); m_ack = 1'b1; end
            else so = 1'b1;
        end else if (r) begin
            if (mq.size() > 0) begin void'(mq.pop_back()); m_ack = 1'b1; end
            else su = 1'b1;
        end
        m_ovf = (c ? 1'b0 : m_ovf) | so;
        m_udf = (c ? 1'b0 : m_udf) | su;
        if (c) m_max = 0;
        if (mq.size() > m_max) m_max = mq.size();
    endtask

    task automatic check_all();
        logic [15:0]  e_ra   = '0;
        logic [239:0] e_regs = '0;
        if (mq.size() > 0) begin
            e_ra   = mq[mq.size()-1].ra;
            e_regs = mq[mq.size()-1].regs;
        end
        chk("ra_out",    256'(ra_out),    256'(e_ra));
        chk("regs_out",  256'(regs_out),  256'(e_regs));
        chk("depth",     256'(depth),     256'(mq.size()));
        chk("max_depth", 256'(max_depth), 256'(m_max));
        chk("full",      256'(full),      256'(mq.size() == 8));
        chk("empty",     256'(empty),     256'(mq.size() == 0));
        chk("overflow",  256'(overflow),  256'(m_ovf));
        chk("underflow", 256'(underflow), 256'(m_udf));
        chk("ack",       256'(ack),       256'(m_ack));
    endtask

    task automatic cycle(input logic b, input logic r, input logic c,
                         input logic [15:0] ra, input logic [239:0] regs);
        frame_t f;
        f.ra = ra;
        f.regs = regs;
        backup = b; restore = r; clr_err = c; ra_in = ra; regs_in = regs;
        @(posedge clk);
        model_step(b, r, c, f);
        #1;
        backup = 1'b0; restore = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    function automatic logic [239:0] rand_regs();
        logic [255:0] v;
        for (int unsigned k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v[239:0];
    endfunction

    task automatic s_cycle(input logic b, input logic r, input logic [31:0] ra);
        s_backup = b; s_restore = r; s_ra_in = ra; s_regs_in = {7{ra ^ 32'h0101_0101}};
        @(posedge clk);
        #1;
        s_backup = 1'b0; s_restore = 1'b0;
    endtask

    initial begin
        reset = 1'b1; backup = 1'b0; restore = 1'b0; clr_err = 1'b0; ra_in = '0; regs_in = '0;
        s_reset = 1'b1; s_backup = 1'b0; s_restore = 1'b0; s_clr_err = 1'b0;
        s_ra_in = '0; s_regs_in = '0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // 1: three pushes then three pops
        for (int i = 1; i <= 3; i++) cycle(1, 0, 0, 16'(i * 16'h10), {15{16'(i * 16'h0101)}});
        chk("t1_ra_top", 256'(ra_out), 256'(16'h0030));
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, '0);
        chk("t1_empty", 256'(empty), 256'(1));

        // 2: nine pushes into a depth-8 stack
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 16'(16'h100 + i), rand_regs());
        chk("t2_ra_slot7", 256'(ra_out), 256'(16'h107));
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0, '0);

        // 3: underflow, clear, and set-wins-over-clear
        cycle(0, 1, 0, '0, '0);
        chk("t3_udf", 256'(underflow), 256'(1));
        cycle(0, 0, 1, '0, '0);
        cycle(0, 1, 0, '0, '0);
        cycle(0, 1, 1, '0, '0);
        chk("t3_udf_set_wins", 256'(underflow), 256'(1));
        cycle(0, 0, 1, '0, '0);

        // 4: swap at depth 2, at depth 0, and while full
        cycle(1, 0, 0, 16'h1111, rand_regs());
        cycle(1, 0, 0, 16'h2222, rand_regs());
        cycle(1, 1, 0, 16'hBEEF, rand_regs());
        chk("t4_swap_ra", 256'(ra_out), 256'(16'hBEEF));
        cycle(0, 1, 0, '0, '0);
        chk("t4_slot0", 256'(ra_out), 256'(16'h1111));
        cycle(0, 1, 0, '0, '0);
        cycle(1, 1, 0, 16'h5A5A, rand_regs());
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 16'(i), rand_regs());
        cycle(1, 1, 0, 16'hC0DE, rand_regs());
        chk("t4_swap_full_no_ovf", 256'(overflow), 256'(0));
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0, '0);
        cycle(0, 0, 1, '0, '0);

        // 5: high-water mark
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 16'(i), rand_regs());
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, '0);
        chk("t5_max5", 256'(max_depth), 256'(5));
        cycle(0, 0, 1, '0, '0);
        chk("t5_max_clr", 256'(max_depth), 256'(0));

        // 6: async reset mid-push at depth 4
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 16'(i), rand_regs());
        backup = 1'b1; ra_in = 16'hDEAD;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        backup = 1'b0;
        #1;
        reset = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned sel = $urandom_range(0, 9);
            logic b = (sel < 4) || (sel == 8);
            logic r = (sel >= 4 && sel < 7) || (sel == 8);
            logic c = ($urandom_range(0, 15) == 0);
            cycle(b, r, c, 16'($urandom), rand_regs());
        end

        // 6b: re-run of test 1 on WIDTH=32, NREGS=7, DEPTH=4
        s_reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            s_cycle(1, 0, 32'(i * 32'h10));
            chk("s_depth_push", 256'(s_depth), 256'(i));
            chk("s_ra_push", 256'(s_ra_out), 256'(32'(i * 32'h10)));
            chk("s_regs_push", 256'(s_regs_out), 256'({7{32'(i * 32'h10) ^ 32'h0101_0101}}));
            chk("s_ack_push", 256'(s_ack), 256'(1));
        end
        for (int i = 2; i >= 0; i--) begin
            s_cycle(0, 1, '0);
            chk("s_depth_pop", 256'(s_depth), 256'(i));
            chk("s_ra_pop", 256'(s_ra_out), 256'(i == 0 ? 32'h0 : 32'(i * 32'h10)));
        end
        chk("s_empty", 256'(s_empty), 256'(1));
        for (int i = 0; i < 5; i++) s_cycle(1, 0, 32'(32'hA0 + i));
        chk("s_full", 256'(s_full), 256'(1));
        chk("s_ovf", 256'(s_overflow), 256'(1));
        chk("s_ack_refused", 256'(s_ack), 256'(0));
        chk("s_ra_full", 256'(s_ra_out), 256'(32'hA3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
